// File: rtl/spectrum_pkg.sv
// Shared types and constants for the Spectrum RAM port-A arbiter.
package spectrum_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGrantCpu,
        StGrantSpi,
        StCapture
    } arb_state_e;

    localparam logic [7:0]  CTRL_PAGE_DEF    = 8'hFF;
    localparam logic [7:0]  RAM_PAGE_DEF     = 8'h00;
    localparam int unsigned CTRL_LOADING_BIT = 1;

endpackage

// File: rtl/req_latch.sv
// One requester's pending bit with its latched address, data and direction.
// A new request may be taken on the same edge the previous one is retired.
module req_latch #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic              clr,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic [7:0]        set_data,
    input  logic              set_wr,
    output logic              accept,
    output logic              pend,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic              wr
);

    logic              pend_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              wr_q;

    assign accept = set && (!pend_q || clr);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else if (accept) begin
            pend_q <= 1'b1;
            addr_q <= set_addr;
            data_q <= set_data;
            wr_q   <= set_wr;
        end else if (clr) begin
            pend_q <= 1'b0;
        end
    end

    assign pend = pend_q;
    assign addr = addr_q;
    assign data = data_q;
    assign wr   = wr_q;

endmodule

// File: rtl/spectrum_ram_arbiter.sv
// Shares RAM port A between the Z80 and the SPI loader, and holds the SPI-written
// control register. Each access is IDLE -> GRANT -> CAPTURE -> IDLE.
module spectrum_ram_arbiter
    import spectrum_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter logic [7:0]  CTRL_PAGE  = CTRL_PAGE_DEF,
    parameter logic [7:0]  RAM_PAGE   = RAM_PAGE_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_ce,
    input  logic              cpu_mreq_n,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              cpu_wait_n,
    input  logic              spi_wr,
    input  logic              spi_rd,
    input  logic [31:0]       spi_addr,
    input  logic [7:0]        spi_wdata,
    output logic [7:0]        spi_rdata,
    output logic              spi_overrun,
    output logic [7:0]        ctrl,
    output logic              loading,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_e state_q, state_d;

    logic [STARVE_W-1:0] starve_q;
    logic [7:0]          ctrl_q;
    logic [7:0]          cpu_din_q;
    logic [7:0]          spi_rdata_q;
    logic                overrun_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [7:0]          ram_din_q;
    logic                serve_spi_q;

    logic              cpu_set, cpu_clr, cpu_accept, cpu_pend, cpu_wr_l;
    logic [ADDR_W-1:0] cpu_addr_l;
    logic [7:0]        cpu_data_l;
    logic              spi_set, spi_clr, spi_accept, spi_pend, spi_wr_l;
    logic [ADDR_W-1:0] spi_addr_l;
    logic [7:0]        spi_data_l;
    logic              ctrl_wr, ctrl_rd, starved;
    logic [7:0]        spi_page;

    assign spi_page = spi_addr[31:24];
    assign cpu_set  = cpu_ce && !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
    assign spi_set  = (spi_wr || spi_rd) && (spi_page == RAM_PAGE);
    assign ctrl_wr  = spi_wr && (spi_page == CTRL_PAGE);
    assign ctrl_rd  = spi_rd && !spi_wr && (spi_page == CTRL_PAGE);
    assign loading  = ctrl_q[CTRL_LOADING_BIT];
    assign starved  = (starve_q == STARVE_W'(STARVE_MAX));

    // Bits between the RAM address and the page byte carry no meaning here.
    if (ADDR_W < 24) begin : g_spi_addr_unused
        logic unused_spi_addr;
        assign unused_spi_addr = ^spi_addr[23:ADDR_W];
    end

    req_latch #(.ADDR_W(ADDR_W)) u_cpu_req (
        .clk      (clk),
        .reset    (reset),
        .set      (cpu_set),
        .clr      (cpu_clr),
        .set_addr (ADDR_W'(cpu_addr)),
        .set_data (cpu_dout),
        .set_wr   (!cpu_wr_n),
        .accept   (cpu_accept),
        .pend     (cpu_pend),
        .addr     (cpu_addr_l),
        .data     (cpu_data_l),
        .wr       (cpu_wr_l)
    );

    req_latch #(.ADDR_W(ADDR_W)) u_spi_req (
        .clk      (clk),
        .reset    (reset),
        .set      (spi_set),
        .clr      (spi_clr),
        .set_addr (spi_addr[ADDR_W-1:0]),
        .set_data (spi_wdata),
        .set_wr   (spi_wr),
        .accept   (spi_accept),
        .pend     (spi_pend),
        .addr     (spi_addr_l),
        .data     (spi_data_l),
        .wr       (spi_wr_l)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (spi_pend && (loading || !cpu_pend || starved)) begin
                    state_d = StGrantSpi;
                end else if (cpu_pend && !loading) begin
                    state_d = StGrantCpu;
                end
            end
            StGrantCpu, StGrantSpi: state_d = StCapture;
            StCapture:              state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    // Reset gates the strobe combinationally so no write lands on the reset edge.
    always_comb begin
        ram_we  = 1'b0;
        cpu_clr = 1'b0;
        spi_clr = 1'b0;
        unique case (state_q)
            StGrantCpu: ram_we  = cpu_wr_l && !reset;
            StGrantSpi: ram_we  = spi_wr_l && !reset;
            StCapture: begin
                cpu_clr = !serve_spi_q;
                spi_clr = serve_spi_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q    <= '0;
            ctrl_q      <= '0;
            cpu_din_q   <= '0;
            spi_rdata_q <= '0;
            overrun_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            serve_spi_q <= 1'b0;
        end else begin
            if (state_d == StGrantCpu) begin
                ram_addr_q  <= cpu_addr_l;
                ram_din_q   <= cpu_data_l;
                serve_spi_q <= 1'b0;
                if (spi_pend && !starved) begin
                    starve_q <= starve_q + 1'b1;
                end
            end else if (state_d == StGrantSpi) begin
                ram_addr_q  <= spi_addr_l;
                ram_din_q   <= spi_data_l;
                serve_spi_q <= 1'b1;
                starve_q    <= '0;
            end
            if (cpu_clr && !cpu_wr_l) begin
                cpu_din_q <= ram_dout;
            end
            if (ctrl_rd) begin
                spi_rdata_q <= ctrl_q;
            end else if (spi_clr && !spi_wr_l) begin
                spi_rdata_q <= ram_dout;
            end
            if (ctrl_wr) begin
                ctrl_q <= spi_wdata;
            end
            if (spi_set && !spi_accept) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign cpu_din     = cpu_din_q;
    assign cpu_wait_n  = !cpu_pend;
    assign spi_rdata   = spi_rdata_q;
    assign spi_overrun = overrun_q;
    assign ctrl        = ctrl_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;

endmodule

// File: tb/tb_spectrum_ram_arbiter.sv
// Directed bench for spectrum_ram_arbiter with a behavioural synchronous RAM.
module tb_spectrum_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_ce, cpu_mreq_n, cpu_rd_n, cpu_wr_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout, cpu_din;
    logic        cpu_wait_n;
    logic        spi_wr, spi_rd;
    logic [31:0] spi_addr;
    logic [7:0]  spi_wdata, spi_rdata;
    logic        spi_overrun;
    logic [7:0]  ctrl;
    logic        loading;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_din, ram_dout;

    logic [7:0] mem [0:65535];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    spectrum_ram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_ce      (cpu_ce),
        .cpu_mreq_n  (cpu_mreq_n),
        .cpu_rd_n    (cpu_rd_n),
        .cpu_wr_n    (cpu_wr_n),
        .cpu_addr    (cpu_addr),
        .cpu_dout    (cpu_dout),
        .cpu_din     (cpu_din),
        .cpu_wait_n  (cpu_wait_n),
        .spi_wr      (spi_wr),
        .spi_rd      (spi_rd),
        .spi_addr    (spi_addr),
        .spi_wdata   (spi_wdata),
        .spi_rdata   (spi_rdata),
        .spi_overrun (spi_overrun),
        .ctrl        (ctrl),
        .loading     (loading),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    // RAM model: read-before-write, one cycle latency.
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        if (ram_we) mem[ram_addr] = ram_din;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_ce = 1'b0; cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (ctrl !== 8'h00) $display("FAIL reset_ctrl got %h want 00", ctrl); else passes++;
        checks++; if (loading !== 1'b0) $display("FAIL reset_loading got %b want 0", loading); else passes++;
        checks++; if ({cpu_din, spi_rdata} !== 16'h0000)
            $display("FAIL reset_rdata got %h want 0000", {cpu_din, spi_rdata}); else passes++;
        checks++; if ({spi_overrun, ram_we} !== 2'b00)
            $display("FAIL reset_flags got %b want 00", {spi_overrun, ram_we}); else passes++;
        checks++; if ({ram_addr, ram_din} !== 24'h0)
            $display("FAIL reset_ram got %h want 000000", {ram_addr, ram_din}); else passes++;
        checks++; if (cpu_wait_n !== 1'b1) $display("FAIL reset_wait got %b want 1", cpu_wait_n); else passes++;
    endtask

    task automatic test_ctrl();
        logic saw_we;
        spi_wr = 1'b1; spi_addr = 32'hFF00_0000; spi_wdata = 8'h02;
        saw_we = ram_we;
        tick();
        spi_wr = 1'b0;
        checks++; if (ctrl !== 8'h02) $display("FAIL ctrl_write got %h want 02", ctrl); else passes++;
        checks++; if (loading !== 1'b1) $display("FAIL ctrl_loading got %b want 1", loading); else passes++;
        for (int i = 0; i < 4; i++) begin
            saw_we |= ram_we;
            tick();
        end
        checks++; if (saw_we !== 1'b0) $display("FAIL ctrl_no_we got %b want 0", saw_we); else passes++;
        spi_rd = 1'b1; spi_addr = 32'hFF00_0000;
        tick();
        spi_rd = 1'b0;
        checks++; if (spi_rdata !== 8'h02) $display("FAIL ctrl_read got %h want 02", spi_rdata); else passes++;
    endtask

    task automatic test_loading_write();
        logic saw_we;
        // Concurrent CPU read and SPI write with loading=1.
        cpu_ce = 1'b1; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_addr = 16'h4000;
        spi_wr = 1'b1; spi_addr = 32'h0000_4000; spi_wdata = 8'hA5;
        tick();
        cpu_idle(); spi_wr = 1'b0;
        tick();
        checks++; if ({ram_we, ram_addr, ram_din} !== {1'b1, 16'h4000, 8'hA5})
            $display("FAIL load_grant got %b/%h/%h want 1/4000/a5", ram_we, ram_addr, ram_din);
        else passes++;
        tick();
        checks++; if (ram_we !== 1'b0) $display("FAIL load_we_once got %b want 0", ram_we); else passes++;
        saw_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw_we |= ram_we;
        end
        checks++; if ({cpu_wait_n, saw_we} !== 2'b00)
            $display("FAIL load_cpu_held got %b want 00", {cpu_wait_n, saw_we}); else passes++;
        spi_wr = 1'b1; spi_addr = 32'hFF00_0000; spi_wdata = 8'h00;
        tick();
        spi_wr = 1'b0;
        tick();
        checks++; if ({ram_we, ram_addr} !== {1'b0, 16'h4000})
            $display("FAIL load_cpu_grant got %b/%h want 0/4000", ram_we, ram_addr); else passes++;
        tick();
        tick();
        checks++; if ({cpu_wait_n, cpu_din} !== {1'b1, 8'hA5})
            $display("FAIL load_cpu_read got %b/%h want 1/a5", cpu_wait_n, cpu_din); else passes++;
    endtask

    task automatic test_simultaneous();
        cpu_ce = 1'b1; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_addr = 16'h4000;
        spi_rd = 1'b1; spi_addr = 32'h0000_0001;
        tick();
        cpu_idle(); spi_rd = 1'b0;
        tick();
        checks++; if (ram_addr !== 16'h4000) $display("FAIL sim_cpu_first got %h want 4000", ram_addr); else passes++;
        tick();
        checks++; if (cpu_wait_n !== 1'b0) $display("FAIL sim_wait_low got %b want 0", cpu_wait_n); else passes++;
        tick();
        checks++; if ({cpu_wait_n, cpu_din} !== {1'b1, 8'hA5})
            $display("FAIL sim_cpu_data got %b/%h want 1/a5", cpu_wait_n, cpu_din); else passes++;
        tick();
        checks++; if (ram_addr !== 16'h0001) $display("FAIL sim_spi_grant got %h want 0001", ram_addr); else passes++;
        tick();
        tick();
        checks++; if (spi_rdata !== 8'h3D) $display("FAIL sim_spi_data got %h want 3d", spi_rdata); else passes++;
    endtask

    task automatic test_starve();
        int          cpu_grants = 0;
        logic        found = 1'b0;
        logic [15:0] prev = 16'hFFFF;
        cpu_ce = 1'b1; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_addr = 16'h0100;
        spi_rd = 1'b1; spi_addr = 32'h0000_0020;
        tick();
        spi_rd = 1'b0;
        for (int k = 1; k < 40 && !found; k++) begin
            cpu_addr = 16'h0100 + 16'(k);
            tick();
            if (ram_addr == 16'h0020) found = 1'b1;
            else if (ram_addr[15:8] == 8'h01 && ram_addr != prev) cpu_grants++;
            prev = ram_addr;
        end
        cpu_idle();
        checks++; if (found !== 1'b1) $display("FAIL starve_spi_granted got %b want 1", found); else passes++;
        checks++; if (cpu_grants != 4) $display("FAIL starve_count got %0d want 4", cpu_grants); else passes++;
        tick();
        tick();
        checks++; if (spi_rdata !== 8'h1C) $display("FAIL starve_spi_data got %h want 1c", spi_rdata); else passes++;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (cpu_wait_n !== 1'b1) $display("FAIL starve_cpu_drain got %b want 1", cpu_wait_n); else passes++;
    endtask

    task automatic test_overrun();
        spi_wr = 1'b1; spi_addr = 32'h0000_0030; spi_wdata = 8'h11;
        tick();
        spi_addr = 32'h0000_0031; spi_wdata = 8'h22;
        checks++; if (spi_overrun !== 1'b0) $display("FAIL ovr_before got %b want 0", spi_overrun); else passes++;
        tick();
        spi_wr = 1'b0;
        checks++; if (spi_overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", spi_overrun); else passes++;
        for (int i = 0; i < 6; i++) tick();
        checks++; if ({mem[16'h0030], mem[16'h0031]} !== 16'h110D)
            $display("FAIL ovr_ram got %h want 110d", {mem[16'h0030], mem[16'h0031]}); else passes++;
        checks++; if (spi_overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", spi_overrun); else passes++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (spi_overrun !== 1'b0) $display("FAIL ovr_reset got %b want 0", spi_overrun); else passes++;
    endtask

    task automatic test_reset_mid();
        spi_wr = 1'b1; spi_addr = 32'hFF00_0000; spi_wdata = 8'h80;
        tick();
        spi_wr = 1'b0;
        cpu_ce = 1'b1; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0; cpu_addr = 16'h0040; cpu_dout = 8'h77;
        tick();
        cpu_idle();
        tick();
        checks++; if ({ram_we, ram_addr} !== {1'b1, 16'h0040})
            $display("FAIL mid_grant got %b/%h want 1/0040", ram_we, ram_addr); else passes++;
        reset = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b0) $display("FAIL mid_we_drop got %b want 0", ram_we); else passes++;
        tick();
        reset = 1'b0;
        checks++; if ({cpu_wait_n, ctrl} !== {1'b1, 8'h00})
            $display("FAIL mid_after got %b/%h want 1/00", cpu_wait_n, ctrl); else passes++;
        checks++; if (mem[16'h0040] !== 8'h7C)
            $display("FAIL mid_no_write got %h want 7c", mem[16'h0040]); else passes++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h3C;
        reset = 1'b1;
        cpu_idle();
        cpu_addr = '0; cpu_dout = '0;
        spi_wr = 1'b0; spi_rd = 1'b0; spi_addr = '0; spi_wdata = '0;
        test_reset();
        test_ctrl();
        test_loading_write();
        test_simultaneous();
        test_starve();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
